fft_stage_sequencer: RTL

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_stage_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - radix-2 FFT stage/bundle sequencer with per-lane twiddle indices.
// Optional cycle counter built only when FFT_SEQ_PERF_EN is defined.
module fft_stage_sequencer #(
  parameter int LOGN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  load_ready,
  output logic [LOGN-1:0]       ld_addr,
  output logic                  bf_valid,
  input  logic                  bf_ready,
  output logic [3:0]            bf_stage,
  output logic [LOGN-2:0]       bf_base,
  output logic [8*(LOGN+1)-1:0] tw_idx,
  output logic                  bf_last,
  input  logic                  wb_done,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           perf_cycles
);

  localparam int TW = LOGN + 1;
  localparam int N  = 1 << LOGN;
  localparam logic [LOGN-1:0] LD_LAST    = '1;
  localparam logic [LOGN-2:0] LAST_BASE  = (LOGN-1)'(N/2 - 8);
  localparam logic [LOGN-2:0] BASE_STEP  = (LOGN-1)'(8);
  localparam logic [3:0]      STAGE_LAST = 4'(LOGN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_FINISH} state_t;
  state_t state;

  // Lane k twiddle: 2^s + ((base+k) >> (LOGN-s)); base is a multiple of 8 so base+k never carries out.
  function automatic logic [8*TW-1:0] calc_tw(input logic [3:0] s, input logic [LOGN-2:0] base);
    logic [8*TW-1:0] r;
    logic [TW-1:0]   b;
    logic [TW-1:0]   one;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b   = TW'(base) + TW'(k);
      one = TW'(1) << s;
      r[k*TW +: TW] = one + (b >> (LOGN - int'(s)));
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      load_ready <= 1'b0;
      ld_addr    <= '0;
      bf_valid   <= 1'b0;
      bf_stage   <= '0;
      bf_base    <= '0;
      tw_idx     <= '0;
      bf_last    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            load_ready <= 1'b1;
            ld_addr    <= '0;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (ld_addr == LD_LAST) begin
              state      <= S_RUN;
              load_ready <= 1'b0;
              bf_valid   <= 1'b1;
              bf_stage   <= 4'd1;
              bf_base    <= '0;
              tw_idx     <= calc_tw(4'd1, '0);
              bf_last    <= (LAST_BASE == '0);
            end else begin
              ld_addr <= ld_addr + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bf_ready) begin
            if (bf_last) begin
              state    <= S_WAIT;
              bf_valid <= 1'b0;
            end else begin
              bf_base <= bf_base + BASE_STEP;
              tw_idx  <= calc_tw(bf_stage, bf_base + BASE_STEP);
              bf_last <= ((bf_base + BASE_STEP) == LAST_BASE);
            end
          end
        end
        S_WAIT: begin
          if (wb_done) begin
            if (bf_stage < STAGE_LAST) begin
              state    <= S_RUN;
              bf_valid <= 1'b1;
              bf_stage <= bf_stage + 4'd1;
              bf_base  <= '0;
              tw_idx   <= calc_tw(bf_stage + 4'd1, '0);
              bf_last  <= (LAST_BASE == '0);
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule
